mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_if.sv | 21 ++
 rtl/mult_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// The pipeline side is the master and the unit is the slave.
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, MDOp, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, MDOp, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit that owns the HI/LO registers.
// The result is computed at issue and held in temp registers until the busy window ends.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_temp_hi;
    logic [31:0]        r_temp_lo;
    logic               r_div_zero;

    md_op_t             w_op;
    logic               w_accept;
    logic               w_commit;
    logic [CNT_W-1:0]   w_cnt_load;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_is_div;
    logic               w_b_zero;

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [31:0] w_divisor;
    logic signed [31:0] w_quot_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quot_u;
    logic        [31:0] w_rem_u;
    logic               w_div_ovf;

    assign w_op     = md_op_t'(bus.MDOp);
    assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign w_b_zero = (bus.B == 32'd0);

    // Substituting 1 for a zero divisor keeps X out of the datapath; that result is never committed.
    assign w_divisor = w_b_zero ? 32'd1 : bus.B;
    assign w_div_ovf = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);

    assign w_prod_s = $signed(bus.A) * $signed(bus.B);
    assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    assign w_quot_s = $signed(bus.A) / $signed(w_divisor);
    assign w_rem_s  = $signed(bus.A) % $signed(w_divisor);
    assign w_quot_u = bus.A / w_divisor;
    assign w_rem_u  = bus.A % w_divisor;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_res_hi   = 32'd0;
        w_res_lo   = 32'd0;
        w_cnt_load = CNT_W'(MULT_CYCLES);
        case (w_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            OP_DIV: begin
                w_cnt_load = CNT_W'(DIV_CYCLES);
                // The single signed overflow case has a fixed architectural result.
                if (w_div_ovf) begin
                    w_res_hi = 32'd0;
                    w_res_lo = 32'h8000_0000;
                end else begin
                    w_res_hi = w_rem_s;
                    w_res_lo = w_quot_s;
                end
            end
            OP_DIVU: begin
                w_cnt_load = CNT_W'(DIV_CYCLES);
                w_res_hi   = w_rem_u;
                w_res_lo   = w_quot_u;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && (w_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU})) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_commit     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_temp_hi  <= 32'd0;
            r_temp_lo  <= 32'd0;
            r_div_zero <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_temp_hi  <= w_res_hi;
                r_temp_lo  <= w_res_lo;
                r_div_zero <= w_is_div && w_b_zero;
                r_cnt      <= w_cnt_load;
                r_busy     <= (w_cnt_load != '0);
            end
            // Moves to HI/LO act in IDLE regardless of start.
            if (w_op == OP_MTHI) begin
                r_hi <= bus.A;
            end
            if (w_op == OP_MTLO) begin
                r_lo <= bus.A;
            end
        end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_busy <= (r_cnt != CNT_W'(1));
            if (w_commit && !r_div_zero) begin
                r_hi <= r_temp_hi;
                r_lo <= r_temp_lo;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: arithmetic, timing, interference and reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mult_div_unit_if md_if ();

    mult_div_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (md_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        md_if.start = 1'b0;
        md_if.MDOp  = 3'd0;
        md_if.A     = 32'd0;
        md_if.B     = 32'd0;
    endtask

    // Called at a falling edge; issues op for one cycle and checks the whole busy window.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          busy_bad;
        int          hold_bad;
        old_hi = md_if.HI;
        old_lo = md_if.LO;
        md_if.start = 1'b1;
        md_if.MDOp  = op;
        md_if.A     = a;
        md_if.B     = b;
        @(negedge clk);
        idle_inputs();
        busy_bad = 0;
        hold_bad = 0;
        for (int k = 0; k < n; k++) begin
            if (md_if.busy !== 1'b1) busy_bad++;
            if (md_if.HI !== old_hi || md_if.LO !== old_lo) hold_bad++;
            @(negedge clk);
        end
        cmp({name, " busy_high_cycles_missing"}, busy_bad, 0);
        cmp({name, " hilo_changed_during_run"}, hold_bad, 0);
        cmp({name, " busy_after"}, {31'd0, md_if.busy}, 32'd0);
        cmp({name, " HI"}, md_if.HI, exp_hi);
        cmp({name, " LO"}, md_if.LO, exp_lo);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        cmp("reset busy", {31'd0, md_if.busy}, 32'd0);
        cmp("reset HI", md_if.HI, 32'd0);
        cmp("reset LO", md_if.LO, 32'd0);
    endtask

    task automatic test_mult();
        run_op("mult -2*3", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'h0000_0003, MULT_N, 32'h0000_0002, 32'hFFFF_FFFA);
    endtask

    task automatic test_div();
        run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/2", 3'd4, 32'h0000_0007, 32'h0000_0002, DIV_N, 32'h0000_0001, 32'h0000_0003);
        run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0000_0000, 32'h8000_0000);
        run_op("div 7/-2", 3'd3, 32'h0000_0007, 32'hFFFF_FFFE, DIV_N, 32'h0000_0001, 32'hFFFF_FFFD);
    endtask

    task automatic test_div_zero();
        md_if.MDOp = 3'd6;
        md_if.A    = 32'h11;
        @(negedge clk);
        md_if.MDOp = 3'd5;
        md_if.A    = 32'h22;
        @(negedge clk);
        idle_inputs();
        cmp("mtlo LO", md_if.LO, 32'h11);
        cmp("mthi HI", md_if.HI, 32'h22);
        cmp("mt busy", {31'd0, md_if.busy}, 32'd0);
        run_op("div by 0", 3'd3, 32'h1234_5678, 32'd0, DIV_N, 32'h22, 32'h11);
        run_op("divu by 0", 3'd4, 32'h1234_5678, 32'd0, DIV_N, 32'h22, 32'h11);
    endtask

    task automatic test_busy_interference();
        int busy_cnt;
        md_if.start = 1'b1;
        md_if.MDOp  = 3'd1;
        md_if.A     = 32'd5;
        md_if.B     = 32'd7;
        @(negedge clk);
        busy_cnt = 0;
        if (md_if.busy === 1'b1) busy_cnt++;
        // Restart attempt, then a mthi, both while running.
        md_if.start = 1'b1;
        md_if.MDOp  = 3'd3;
        md_if.A     = 32'd100;
        md_if.B     = 32'd3;
        @(negedge clk);
        if (md_if.busy === 1'b1) busy_cnt++;
        md_if.start = 1'b0;
        md_if.MDOp  = 3'd5;
        md_if.A     = 32'hDEAD;
        @(negedge clk);
        if (md_if.busy === 1'b1) busy_cnt++;
        idle_inputs();
        cmp("interf HI held", md_if.HI, 32'h22);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (md_if.busy === 1'b1) busy_cnt++;
        end
        cmp("interf busy cycles", busy_cnt, MULT_N);
        cmp("interf HI", md_if.HI, 32'd0);
        cmp("interf LO", md_if.LO, 32'd35);
    endtask

    task automatic test_reset_mid();
        int late_bad;
        md_if.start = 1'b1;
        md_if.MDOp  = 3'd3;
        md_if.A     = 32'd100;
        md_if.B     = 32'd7;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        cmp("rstmid busy before", {31'd0, md_if.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("rstmid busy", {31'd0, md_if.busy}, 32'd0);
        cmp("rstmid HI", md_if.HI, 32'd0);
        cmp("rstmid LO", md_if.LO, 32'd0);
        late_bad = 0;
        for (int k = 0; k < DIV_N + 2; k++) begin
            @(negedge clk);
            if (md_if.busy !== 1'b0 || md_if.HI !== 32'd0 || md_if.LO !== 32'd0) late_bad++;
        end
        cmp("rstmid no late commit", late_bad, 0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b mult", 3'd2, 32'h0001_0000, 32'h0001_0000, MULT_N, 32'h0000_0001, 32'h0000_0000);
        run_op("b2b divu", 3'd4, 32'd100, 32'd7, DIV_N, 32'd2, 32'd14);
        run_op("b2b mult2", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, 32'h0000_0000, 32'h0000_0001);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_interference();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
